ws_conv_sequencer: RTL and testbench

- Hardware instruction sequencer for the weight-stationary core. It replaces bench-driven stepping with autonomous control.
- Per kernel position kij it performs three steps:
  - streams COL weight rows from XMEM into L0 and loads them into the array;
  - streams all activation rows through the array;
  - flushes the array, and drains OFIFO psums into PMEM concurrently.
- After all kij, an accumulation phase reads PMEM in convolution order and pulses acc, so the SFP produces each output pixel.
- It sits between the top-level start/done control and the core's inst fields.

---
 rtl/ws_conv_sequencer_if.sv | 34 +++
 rtl/ws_conv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ws_conv_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws_conv_sequencer_if.sv
// Control/bus bundle between the conv sequencer and the weight-stationary core.
// The master side is the sequencer. The slave side is the core and the top-level control.
interface ws_conv_sequencer_if #(
  parameter int unsigned AW = 11
);
  logic          start;
  logic          l0_ready;
  logic          ofifo_valid;
  logic          xmem_cen;
  logic          xmem_wen;
  logic [AW-1:0] xmem_addr;
  logic          load;
  logic          execute;
  logic          mode;
  logic          pmem_cen;
  logic          pmem_wen;
  logic [AW-1:0] pmem_addr;
  logic          ofifo_rd;
  logic          acc;
  logic          busy;
  logic          done;

  modport master (
    input  start, l0_ready, ofifo_valid,
    output xmem_cen, xmem_wen, xmem_addr, load, execute, mode,
           pmem_cen, pmem_wen, pmem_addr, ofifo_rd, acc, busy, done
  );

  modport slave (
    output start, l0_ready, ofifo_valid,
    input  xmem_cen, xmem_wen, xmem_addr, load, execute, mode,
           pmem_cen, pmem_wen, pmem_addr, ofifo_rd, acc, busy, done
  );
endinterface

// File: rtl/ws_conv_sequencer.sv
// Autonomous layer sequencer: per-kij weight load, activation stream and flush,
// a concurrent OFIFO->PMEM drain, then a PMEM accumulation sweep that strobes the SFP.
module ws_conv_sequencer #(
  parameter int unsigned COL    = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned I_W    = 4,
  parameter int unsigned X_BASE = 0,
  parameter int unsigned W_BASE = 128,
  parameter int unsigned P_BASE = 0,
  parameter int unsigned GAP    = 19,
  parameter int unsigned AW     = 11
) (
  input  logic               clk,
  input  logic               reset,
  ws_conv_sequencer_if.master bus
);
  localparam int unsigned LEN_KIJ = K * K;
  localparam int unsigned LEN_NIJ = I_W * I_W;
  localparam int unsigned O_W     = I_W - K + 1;
  localparam int unsigned TOTAL   = LEN_KIJ * LEN_NIJ;

  typedef enum logic [2:0] {
    S_IDLE, S_LOADW, S_EXEC, S_FLUSH, S_GAP, S_WAITDRAIN, S_ACC, S_FIN
  } state_t;

  state_t        state;
  logic [31:0]   kij, t, g, wcount;
  logic [31:0]   r, kx, ky, ox, oy;
  logic [AW-1:0] acc_addr;

  // kx/ky and ox/oy track kij%K, kij/K and the output coordinates without dividers.
  always_comb acc_addr = AW'(P_BASE + r * LEN_NIJ + (oy + ky) * I_W + ox + kx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      kij    <= '0; t  <= '0; g  <= '0; wcount <= '0;
      r      <= '0; kx <= '0; ky <= '0; ox <= '0; oy <= '0;
      bus.xmem_cen  <= 1'b1; bus.xmem_wen <= 1'b1; bus.xmem_addr <= '0;
      bus.pmem_cen  <= 1'b1; bus.pmem_wen <= 1'b1; bus.pmem_addr <= '0;
      bus.load      <= 1'b0; bus.execute  <= 1'b0; bus.mode      <= 1'b0;
      bus.ofifo_rd  <= 1'b0; bus.acc      <= 1'b0;
      bus.busy      <= 1'b0; bus.done     <= 1'b0;
    end else begin
      // Drain runs beside the FSM; the ACC branch below overrides PMEM only after it has finished.
      if (state != S_IDLE && wcount < TOTAL && bus.ofifo_valid) begin
        bus.ofifo_rd  <= 1'b1;
        bus.pmem_cen  <= 1'b0;
        bus.pmem_wen  <= 1'b0;
        bus.pmem_addr <= AW'(P_BASE + wcount);
        wcount        <= wcount + 1;
      end else begin
        bus.ofifo_rd <= 1'b0;
        bus.pmem_cen <= 1'b1;
        bus.pmem_wen <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          kij <= '0; t  <= '0; g  <= '0; wcount <= '0;
          r   <= '0; kx <= '0; ky <= '0; ox <= '0; oy <= '0;
          bus.xmem_cen  <= 1'b1; bus.xmem_wen <= 1'b1; bus.xmem_addr <= '0;
          bus.pmem_addr <= '0;
          bus.load      <= 1'b0; bus.execute  <= 1'b0; bus.mode      <= 1'b0;
          bus.acc       <= 1'b0; bus.done     <= 1'b0;
          bus.busy      <= bus.start;
          if (bus.start) state <= S_LOADW;
        end
        S_LOADW: begin
          if (bus.l0_ready) begin
            bus.xmem_cen  <= 1'b0;
            bus.xmem_addr <= AW'(W_BASE + kij * COL + t);
            bus.load      <= 1'b1;
            bus.execute   <= 1'b0;
            bus.mode      <= 1'b0;
            if (t == COL - 1) begin
              t     <= '0;
              state <= S_EXEC;
            end else begin
              t <= t + 1;
            end
          end else begin
            bus.xmem_cen <= 1'b1;
          end
        end
        S_EXEC: begin
          if (bus.l0_ready) begin
            bus.xmem_cen  <= 1'b0;
            bus.xmem_addr <= AW'(X_BASE + t);
            bus.load      <= 1'b0;
            bus.execute   <= 1'b1;
            bus.mode      <= 1'b0;
            if (t == LEN_NIJ - 1) begin
              t     <= '0;
              state <= S_FLUSH;
            end else begin
              t <= t + 1;
            end
          end else begin
            bus.xmem_cen <= 1'b1;
          end
        end
        S_FLUSH: begin
          bus.xmem_cen <= 1'b1;
          bus.load     <= 1'b1;
          bus.execute  <= 1'b1;
          bus.mode     <= 1'b1;
          g            <= '0;
          state        <= S_GAP;
        end
        S_GAP: begin
          bus.load    <= 1'b0;
          bus.execute <= 1'b0;
          bus.mode    <= 1'b0;
          if (g == GAP - 1) begin
            g   <= '0;
            kij <= kij + 1;
            state <= (kij == LEN_KIJ - 1) ? S_WAITDRAIN : S_LOADW;
          end else begin
            g <= g + 1;
          end
        end
        S_WAITDRAIN: begin
          if (wcount == TOTAL) state <= S_ACC;
        end
        S_ACC: begin
          // Per output: LEN_KIJ reads, one trailing acc cycle, then one idle boundary cycle.
          if (r < LEN_KIJ) begin
            bus.pmem_cen  <= 1'b0;
            bus.pmem_wen  <= 1'b1;
            bus.pmem_addr <= acc_addr;
            bus.acc       <= (r != 0);
            r             <= r + 1;
            if (kx == K - 1) begin
              kx <= '0;
              ky <= ky + 1;
            end else begin
              kx <= kx + 1;
            end
          end else if (r == LEN_KIJ) begin
            bus.acc <= 1'b1;
            r       <= r + 1;
          end else begin
            bus.acc <= 1'b0;
            r  <= '0;
            kx <= '0;
            ky <= '0;
            if (ox == O_W - 1) begin
              ox <= '0;
              if (oy == O_W - 1) state <= S_FIN;
              else oy <= oy + 1;
            end else begin
              ox <= ox + 1;
            end
          end
        end
        S_FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ws_conv_sequencer.sv
// Directed bench for ws_conv_sequencer with COL=8, K=3, I_W=4, GAP=19.
module tb_ws_conv_sequencer;
  localparam int unsigned AW = 11;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  ws_conv_sequencer_if #(.AW(AW)) bus ();

  ws_conv_sequencer #(
    .COL(8), .K(3), .I_W(4), .X_BASE(0), .W_BASE(128), .P_BASE(0), .GAP(19), .AW(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.l0_ready = 1'b0; bus.ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.xmem_cen, bus.xmem_wen, bus.pmem_cen, bus.pmem_wen} !== 4'b1111)
      $display("FAIL reset_enables got %b want 1111", {bus.xmem_cen, bus.xmem_wen, bus.pmem_cen, bus.pmem_wen});
    else passes++;
    checks++;
    if ({bus.xmem_addr, bus.pmem_addr} !== 22'd0)
      $display("FAIL reset_addrs got %0d/%0d want 0/0", bus.xmem_addr, bus.pmem_addr);
    else passes++;
    checks++;
    if ({bus.load, bus.execute, bus.mode, bus.ofifo_rd, bus.acc, bus.busy, bus.done} !== 7'b0)
      $display("FAIL reset_ctrl got %b want 0000000", {bus.load, bus.execute, bus.mode, bus.ofifo_rd, bus.acc, bus.busy, bus.done});
    else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.xmem_cen !== 1'b1)
      $display("FAIL idle_after_reset got busy=%b cen=%b want 0/1", bus.busy, bus.xmem_cen);
    else passes++;
  endtask

  // l0_ready always 1, ofifo_valid 0; a start pulse mid-run must be ignored.
  task automatic test_basic();
    int   addr_q[$];
    int   cyc_q[$];
    logic ld_q[$];
    logic ex_q[$];
    int   flush_cyc = -1;
    int   flush_cnt = 0;
    int   pmem_acc = 0;
    int   done_cnt = 0;
    int   exp;
    bus.l0_ready = 1'b1; bus.ofifo_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 460; c++) begin
      @(negedge clk);
      bus.start = (c == 100);
      if (bus.xmem_cen === 1'b0) begin
        addr_q.push_back(int'(bus.xmem_addr));
        cyc_q.push_back(c);
        ld_q.push_back(bus.load);
        ex_q.push_back(bus.execute);
      end
      if (bus.load === 1'b1 && bus.execute === 1'b1 && bus.mode === 1'b1) begin
        flush_cnt++;
        if (flush_cyc < 0) flush_cyc = c;
      end
      if (bus.pmem_cen !== 1'b1 || bus.ofifo_rd !== 1'b0) pmem_acc++;
      if (bus.done !== 1'b0) done_cnt++;
    end
    bus.start = 1'b0;
    checks++;
    if (addr_q.size() != 216) $display("FAIL xmem_read_count got %0d want 216", addr_q.size());
    else passes++;
    if (addr_q.size() == 216) begin
      for (int i = 0; i < 24; i++) begin
        exp = (i < 8) ? 128 + i : i - 8;
        checks++;
        if (addr_q[i] != exp) $display("FAIL kij0_addr[%0d] got %0d want %0d", i, addr_q[i], exp);
        else passes++;
      end
      checks++;
      if (ld_q[0] !== 1'b1 || ex_q[0] !== 1'b0)
        $display("FAIL loadw_ctrl got load=%b exec=%b want 1/0", ld_q[0], ex_q[0]);
      else passes++;
      checks++;
      if (ld_q[8] !== 1'b0 || ex_q[8] !== 1'b1)
        $display("FAIL exec_ctrl got load=%b exec=%b want 0/1", ld_q[8], ex_q[8]);
      else passes++;
      checks++;
      if (flush_cyc != cyc_q[23] + 1) $display("FAIL flush_cycle got %0d want %0d", flush_cyc, cyc_q[23] + 1);
      else passes++;
      checks++;
      if (addr_q[24] != 136) $display("FAIL kij1_first_addr got %0d want 136", addr_q[24]);
      else passes++;
      checks++;
      if (cyc_q[24] != flush_cyc + 20) $display("FAIL kij1_start_cycle got %0d want %0d", cyc_q[24], flush_cyc + 20);
      else passes++;
      checks++;
      if (addr_q[192] != 192 || addr_q[215] != 15)
        $display("FAIL kij8_addrs got %0d,%0d want 192,15", addr_q[192], addr_q[215]);
      else passes++;
    end
    checks++;
    if (flush_cnt != 9) $display("FAIL flush_count got %0d want 9", flush_cnt);
    else passes++;
    checks++;
    if (pmem_acc != 0) $display("FAIL no_pmem_access got %0d want 0", pmem_acc);
    else passes++;
    checks++;
    if (done_cnt != 0 || bus.busy !== 1'b1)
      $display("FAIL waitdrain_stall got done=%0d busy=%b want 0/1", done_cnt, bus.busy);
    else passes++;
  endtask

  task automatic test_drain();
    int bad = 0;
    bus.ofifo_valid = 1'b1;
    for (int i = 0; i < 145; i++) begin
      @(negedge clk);
      if (i == 144) begin
        bus.ofifo_valid = 1'b0;
        checks++;
        if (bus.pmem_cen !== 1'b1 || bus.ofifo_rd !== 1'b0)
          $display("FAIL drain_overflow got cen=%b rd=%b want 1/0", bus.pmem_cen, bus.ofifo_rd);
        else passes++;
      end else begin
        if (bus.pmem_cen !== 1'b0 || bus.pmem_wen !== 1'b0 || bus.ofifo_rd !== 1'b1 ||
            bus.pmem_addr !== i[AW-1:0]) bad++;
        if (i == 0 || i == 143) begin
          checks++;
          if (bus.pmem_addr !== i[AW-1:0] || bus.pmem_cen !== 1'b0)
            $display("FAIL drain_write[%0d] got addr=%0d cen=%b want %0d/0", i, bus.pmem_addr, bus.pmem_cen, i);
          else passes++;
        end
      end
    end
    checks++;
    if (bad != 0) $display("FAIL drain_writes got %0d bad cycles want 0", bad);
    else passes++;
  endtask

  task automatic test_acc();
    int   rd_q[$];
    int   exp0[9] = '{0, 17, 34, 52, 69, 86, 104, 121, 138};
    int   acc_cnt = 0;
    int   lag_bad = 0;
    int   idle_cnt = 0;
    int   done_cyc = -1;
    int   bad = 0;
    int   exp;
    logic busy_at_done = 1'b1;
    logic prev_rd = 1'b0;
    logic cur_rd;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cyc = c;
        busy_at_done = bus.busy;
        break;
      end
      cur_rd = (bus.pmem_cen === 1'b0 && bus.pmem_wen === 1'b1);
      if (cur_rd) rd_q.push_back(int'(bus.pmem_addr));
      if (bus.acc !== prev_rd) lag_bad++;
      if (bus.acc === 1'b1) acc_cnt++;
      if (!cur_rd && bus.acc === 1'b0) idle_cnt++;
      prev_rd = cur_rd;
    end
    checks++;
    if (rd_q.size() != 36) $display("FAIL acc_read_count got %0d want 36", rd_q.size());
    else passes++;
    if (rd_q.size() == 36) begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (rd_q[k] != exp0[k]) $display("FAIL out0_addr[%0d] got %0d want %0d", k, rd_q[k], exp0[k]);
        else passes++;
      end
      checks++;
      if (rd_q[27] != 5) $display("FAIL out3_first_addr got %0d want 5", rd_q[27]);
      else passes++;
      for (int o = 0; o < 4; o++)
        for (int k = 0; k < 9; k++) begin
          exp = k * 16 + (o / 2 + k / 3) * 4 + (o % 2) + (k % 3);
          if (rd_q[o * 9 + k] != exp) bad++;
        end
      checks++;
      if (bad != 0) $display("FAIL acc_addr_sweep got %0d bad want 0", bad);
      else passes++;
    end
    checks++;
    if (acc_cnt != 36) $display("FAIL acc_count got %0d want 36", acc_cnt);
    else passes++;
    checks++;
    if (lag_bad != 0) $display("FAIL acc_lag got %0d bad want 0", lag_bad);
    else passes++;
    checks++;
    if (idle_cnt != 4) $display("FAIL acc_boundaries got %0d want 4", idle_cnt);
    else passes++;
    checks++;
    if (done_cyc != 44 || busy_at_done !== 1'b0)
      $display("FAIL done_pulse got cycle=%0d busy=%b want 44/0", done_cyc, busy_at_done);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL after_done got done=%b busy=%b want 0/0", bus.done, bus.busy);
    else passes++;
  endtask

  task automatic test_l0_toggle();
    logic cen_q[$];
    int   addr_q[$];
    logic ld_q[$];
    int   wreads = 0;
    int   xreads = 0;
    int   last_w = -1;
    bus.l0_ready = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.l0_ready = (c % 2 == 0);
      @(negedge clk);
      cen_q.push_back(bus.xmem_cen);
      addr_q.push_back(int'(bus.xmem_addr));
      ld_q.push_back(bus.load);
      if (bus.xmem_cen === 1'b0 && bus.load === 1'b1) begin wreads++; last_w = int'(bus.xmem_addr); end
      if (bus.xmem_cen === 1'b0 && bus.execute === 1'b1) xreads++;
    end
    bus.l0_ready = 1'b0;
    checks++;
    if ({cen_q[0], cen_q[1], cen_q[2], cen_q[3]} !== 4'b0101)
      $display("FAIL toggle_cen got %b want 0101", {cen_q[0], cen_q[1], cen_q[2], cen_q[3]});
    else passes++;
    checks++;
    if (addr_q[0] != 128 || addr_q[2] != 129)
      $display("FAIL toggle_addrs got %0d,%0d want 128,129", addr_q[0], addr_q[2]);
    else passes++;
    checks++;
    if (ld_q[1] !== 1'b1) $display("FAIL toggle_load_held got %b want 1", ld_q[1]);
    else passes++;
    checks++;
    if (wreads != 8 || last_w != 135) $display("FAIL toggle_weight_reads got %0d last=%0d want 8/135", wreads, last_w);
    else passes++;
    checks++;
    if (xreads != 12) $display("FAIL toggle_exec_reads got %0d want 12", xreads);
    else passes++;
  endtask

  task automatic test_reset_mid_exec();
    int nrd = 0;
    int nwr = 0;
    int found = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.l0_ready = 1'b1; bus.ofifo_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.ofifo_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 4) bus.ofifo_valid = 1'b0;
      if (bus.pmem_cen === 1'b0 && bus.pmem_wen === 1'b0) nwr++;
      if (bus.xmem_cen === 1'b0) begin
        nrd++;
        if (nrd == 88) begin
          found = 1;
          checks++;
          if (bus.xmem_addr !== 11'd7 || bus.execute !== 1'b1)
            $display("FAIL mid_exec_point got addr=%0d exec=%b want 7/1", bus.xmem_addr, bus.execute);
          else passes++;
          break;
        end
      end
    end
    checks++;
    if (found == 0) $display("FAIL mid_exec_timeout got %0d reads want 88", nrd);
    else passes++;
    checks++;
    if (nwr != 5) $display("FAIL pre_reset_writes got %0d want 5", nwr);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.xmem_cen, bus.xmem_wen, bus.pmem_cen, bus.pmem_wen} !== 4'b1111 ||
        {bus.xmem_addr, bus.pmem_addr} !== 22'd0)
      $display("FAIL async_reset_bus got cen/wen=%b addr=%0d/%0d want 1111 0/0",
               {bus.xmem_cen, bus.xmem_wen, bus.pmem_cen, bus.pmem_wen}, bus.xmem_addr, bus.pmem_addr);
    else passes++;
    checks++;
    if ({bus.load, bus.execute, bus.mode, bus.ofifo_rd, bus.acc, bus.busy, bus.done} !== 7'b0)
      $display("FAIL async_reset_ctrl got %b want 0000000", {bus.load, bus.execute, bus.mode, bus.ofifo_rd, bus.acc, bus.busy, bus.done});
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.ofifo_valid = 1'b1;
    @(negedge clk);
    bus.ofifo_valid = 1'b0;
    checks++;
    if (bus.xmem_cen !== 1'b0 || bus.xmem_addr !== 11'd128)
      $display("FAIL restart_first_read got cen=%b addr=%0d want 0/128", bus.xmem_cen, bus.xmem_addr);
    else passes++;
    checks++;
    if (bus.pmem_cen !== 1'b0 || bus.pmem_addr !== 11'd0)
      $display("FAIL restart_first_write got cen=%b addr=%0d want 0/0", bus.pmem_cen, bus.pmem_addr);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_acc();
    test_l0_toggle();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
